axis_arb_mux: RTL

Packet-aware N:1 AXI-Stream multiplexer, successor to axis_mux.
- Adds selectable arbitration: round-robin or fixed priority.
- Adds a configurable packet burst allowance per grant.
- Outputs the source index on M_axis_user.
- Output stage is registered.
- Sits between per-channel packet producers (DMA/report generators) and a single shared stream sink; packets are never interleaved.

---
 rtl/axis_arb_mux.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/axis_arb_mux.sv
// axis_arb_mux: packet-aware N:1 AXI-Stream multiplexer with a registered
// output stage. An input holds the grant for a whole packet (packets are
// never interleaved) and optionally for several back-to-back packets.
// Arbitration is round-robin or fixed priority (lowest index wins).
//
// Ports:
//   Clk, Rst        clock (rising edge), asynchronous active-high reset
//   S_axis_valid    per-input valid
//   S_axis_data     per-input data (unpacked array of NUM_INPUTS vectors)
//   S_axis_last     per-input end of packet
//   S_axis_ready    per-input ready, at most one bit high (combinational)
//   M_axis_ready    downstream ready
//   M_axis_valid    output valid (registered)
//   M_axis_data     output data (registered)
//   M_axis_last     output end of packet (registered)
//   M_axis_user     index of the input that produced the beat (registered)
module axis_arb_mux #(
  parameter int unsigned  AXI_DATA_WIDTH    = 32,
  parameter int unsigned  NUM_INPUTS        = 4,
  parameter int unsigned  ARB_MODE          = 0,
  parameter int unsigned  MAX_BURST_PACKETS = 1,
  localparam int unsigned USER_WIDTH        = ($clog2(NUM_INPUTS) > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NUM_INPUTS-1:0]     S_axis_valid,
  input  logic [AXI_DATA_WIDTH-1:0] S_axis_data [NUM_INPUTS],
  input  logic [NUM_INPUTS-1:0]     S_axis_last,
  output logic [NUM_INPUTS-1:0]     S_axis_ready,
  input  logic                      M_axis_ready,
  output logic                      M_axis_valid,
  output logic [AXI_DATA_WIDTH-1:0] M_axis_data,
  output logic                      M_axis_last,
  output logic [USER_WIDTH-1:0]     M_axis_user
);

  localparam int unsigned           BURST_W  = $clog2(MAX_BURST_PACKETS + 1);
  localparam logic [USER_WIDTH-1:0] LAST_IDX = USER_WIDTH'(NUM_INPUTS - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t                r_state;
  logic [USER_WIDTH-1:0] r_grant;
  logic [USER_WIDTH-1:0] r_rr_ptr;
  logic [BURST_W-1:0]    r_burst_cnt;

  logic                  w_out_free;
  logic                  w_accept;
  logic                  w_last_in;
  logic                  w_burst_more;
  logic                  w_found;
  logic [USER_WIDTH-1:0] w_winner;
  logic [USER_WIDTH-1:0] w_base;
  logic [USER_WIDTH-1:0] w_next_ptr;

  // Index 'off' positions above 'base', wrapping at NUM_INPUTS.
  function automatic logic [USER_WIDTH-1:0] wrap_idx(input logic [USER_WIDTH-1:0] base,
                                                     input int unsigned           off);
    int unsigned sum;
    sum = 32'(base) + off;
    return USER_WIDTH'(sum % NUM_INPUTS);
  endfunction

  // Output register can take a new beat when empty or being drained this cycle.
  assign w_out_free   = !M_axis_valid || M_axis_ready;
  assign w_accept     = (r_state == ST_ACTIVE) && S_axis_valid[r_grant] && w_out_free;
  assign w_last_in    = S_axis_last[r_grant];
  assign w_burst_more = (32'(r_burst_cnt) + 32'd1) < MAX_BURST_PACKETS;
  assign w_next_ptr   = (r_grant == LAST_IDX) ? '0 : r_grant + USER_WIDTH'(1);

  // Fixed priority always searches from input 0; round-robin from the pointer.
  assign w_base       = (ARB_MODE == 1) ? '0 : r_rr_ptr;

  // First valid input at or above w_base, with wrap.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (!w_found && S_axis_valid[wrap_idx(w_base, i)]) begin
        w_found  = 1'b1;
        w_winner = wrap_idx(w_base, i);
      end
    end
  end

  // Only the granted input sees ready, and only while the output can load.
  always_comb begin
    S_axis_ready = '0;
    if (r_state == ST_ACTIVE) begin
      S_axis_ready[r_grant] = w_out_free;
    end
  end

  // Arbiter FSM and output register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_burst_cnt  <= '0;
      M_axis_valid <= 1'b0;
      M_axis_data  <= '0;
      M_axis_last  <= 1'b0;
      M_axis_user  <= '0;
    end else begin
      if (w_accept) begin
        M_axis_valid <= 1'b1;
        M_axis_data  <= S_axis_data[r_grant];
        M_axis_last  <= w_last_in;
        M_axis_user  <= r_grant;
      end else if (M_axis_ready) begin
        M_axis_valid <= 1'b0;
      end

      case (r_state)
        // One bubble cycle per grant: ready stays low while arbitrating.
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_winner;
            r_state <= ST_ACTIVE;
          end
        end
        // Grant is held until the burst allowance of packets is used up.
        ST_ACTIVE: begin
          if (w_accept && w_last_in) begin
            if (w_burst_more) begin
              r_burst_cnt <= r_burst_cnt + BURST_W'(1);
            end else begin
              r_burst_cnt <= '0;
              r_rr_ptr    <= w_next_ptr;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot0: assert property (@(posedge Clk) disable iff (Rst)
    $onehot0(S_axis_ready));

  a_out_hold: assert property (@(posedge Clk) disable iff (Rst)
    (M_axis_valid && !M_axis_ready) |=>
      (M_axis_valid && $stable(M_axis_data) && $stable(M_axis_last) && $stable(M_axis_user)));

  a_user_in_pkt: assert property (@(posedge Clk) disable iff (Rst)
    (M_axis_valid && M_axis_ready && !M_axis_last) |=>
      (!M_axis_valid || $stable(M_axis_user)));
`endif

endmodule
